vcmd_tx: RTL and testbench
==========================

Name: vcmd_tx

Overview:
Video command transmitter: host-side encoder producing the C/D byte stream consumed by the video command receiver. Takes single-byte write requests (address + data) and emits either a bare data byte, when the receiver's auto-incremented address already matches, or a SetAddr command sequence followed by the data byte. Sits between the host/CPU bus bridge and the byte serializer that drives the video link.

Parameters:
AWIDTH, 18, write address width; legal range 17..24, because the page byte carries bits [AWIDTH-1:16].
DWIDTH, 8, byte width; fixed at 8, and other values are not supported.
KEEPALIVE_CYCLES, 1024, idle cycles before a Noop is emitted; used only with VCMD_TX_KEEPALIVE_EN.

Ports:
ClkIn  in  1  system clock; all logic on posedge.
RstNIn  in  1  synchronous active-low reset.
WrValidIn  in  1  write request valid.
WrReadyOut  out  1  write request accepted this cycle when high with WrValidIn.
WrAddrIn  in  AWIDTH  target byte address.
WrDataIn  in  DWIDTH  byte to write.
InvalidateIn  in  1  one-cycle pulse; forces the next write to resend its address.
ByteValidOut  out  1  ByteOut/DataModeOut valid.
ByteReadyIn  in  1  serializer accepts the byte this cycle.
ByteOut  out  DWIDTH  stream byte.
DataModeOut  out  1  C/D flag: 0 = command byte, 1 = data byte.

Behaviour:
- Reset (RstNIn=0 at posedge):
  - State=IDLE, ShadowValid=0, Shadow=0, latched address/data=0.
  - Outputs: ByteValidOut=0, ByteOut=0, DataModeOut=0, WrReadyOut=0 during reset and 1 from the first cycle after.
- Reset mid-sequence aborts the sequence immediately. The receiver must be reset together with this block.
- States: IDLE, CMD, PAGE, HIGH, LOW, DATA, plus NOOP (optional feature only).
- WrReadyOut=1 only in IDLE. Accept = WrValidIn & WrReadyOut; it latches WrAddrIn into A and WrDataIn into D.
- On accept:
  - If ShadowValid & A==Shadow, go to DATA.
  - Otherwise go to CMD.
- Output bytes per state (all with ByteValidOut=1):
  - CMD: 0x01, DataModeOut=0.
  - PAGE: {zero pad, A[AWIDTH-1:16]}, DataModeOut=0.
  - HIGH: A[15:8], DataModeOut=0.
  - LOW: A[7:0], DataModeOut=0.
  - DATA: D, DataModeOut=1.
- In IDLE: ByteValidOut=0. ByteOut and DataModeOut hold their last values.
- Advance only on ByteValidOut & ByteReadyIn: CMD->PAGE->HIGH->LOW->DATA->IDLE.
- While ByteReadyIn=0, ByteOut and DataModeOut stay stable.
- DATA handshake: Shadow <= A+1, modulo 2^AWIDTH (0x3FFFF+1 = 0x00000), and ShadowValid <= 1.
- Outputs come from registers and state only. There is no combinational path from Wr* or ByteReadyIn to ByteOut or DataModeOut.
- Latency from accept to first byte valid: 1 cycle.
  - Matching write: 2 cycles per write at full ready.
  - Non-matching write: 6 cycles per write.
- InvalidateIn=1 clears ShadowValid at that edge.
  - If it coincides with an accept, the accept sees ShadowValid=0 (full sequence).
  - If it coincides with a DATA handshake, the clear wins over the set.
- Simultaneous WrValidIn in a non-IDLE state is not accepted; the requester holds the request.

Optional Feature:
Macro VCMD_TX_KEEPALIVE_EN.
- Defined:
  - An idle counter increments in IDLE while WrValidIn=0.
  - It clears on accept, on any byte handshake, and on reset.
  - When it reaches KEEPALIVE_CYCLES, the FSM enters NOOP and emits 0x00 with DataModeOut=0 and WrReadyOut=0.
  - On handshake it returns to IDLE and the counter clears.
  - Noop affects neither Shadow nor ShadowValid.
  - A WrValidIn arriving in the same cycle the counter hits its limit is accepted; the write takes priority and no Noop is sent.
- Undefined: no counter, no NOOP state, KEEPALIVE_CYCLES ignored.

Test Plan:
- Reset: hold RstNIn=0 for 3 cycles with WrValidIn=1 -> ByteValidOut=0, WrReadyOut=0; after release, WrReadyOut=1.
- First write A=0x12345, D=0xAB, ByteReadyIn=1 -> stream (C)01, (C)01, (C)23, (C)45, (D)AB; Shadow=0x12346.
- Sequential writes: then A=0x12346 D=0xCD, then A=0x00010 D=0x11 -> (D)CD, then (C)01 (C)00 (C)00 (C)10 (D)11.
- Backpressure: ByteReadyIn=0 for 5 cycles during HIGH -> ByteOut=0x23 and DataModeOut=0 stable throughout, no skipped byte.
- Wrap and invalidate:
  - Write 0x3FFFF then 0x00000 -> second write emits only (D).
  - Pulse InvalidateIn, then write 0x00001 -> full SetAddr sequence.
- Keepalive (macro defined, KEEPALIVE_CYCLES=8): 8 idle cycles -> one (C)00.
  - Next write to Shadow emits only (D).
  - With the macro undefined -> no bytes emitted while idle.

Source files
------------

// File: rtl/vcmd_tx.sv
// Video command transmitter: turns byte writes into the C/D stream (bare data or SetAddr + data).
// Optional keepalive Noop generation is enabled by defining VCMD_TX_KEEPALIVE_EN.
module vcmd_tx #(
   parameter int AWIDTH           = 18,
   parameter int DWIDTH           = 8,
   parameter int KEEPALIVE_CYCLES = 1024
) (
   input  logic              ClkIn,
   input  logic              RstNIn,
   input  logic              WrValidIn,
   output logic              WrReadyOut,
   input  logic [AWIDTH-1:0] WrAddrIn,
   input  logic [DWIDTH-1:0] WrDataIn,
   input  logic              InvalidateIn,
   output logic              ByteValidOut,
   input  logic              ByteReadyIn,
   output logic [DWIDTH-1:0] ByteOut,
   output logic              DataModeOut
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_PAGE, S_HIGH, S_LOW, S_DATA, S_NOOP
   } state_t;

   localparam logic [DWIDTH-1:0] CMD_SETADDR = DWIDTH'(1);
   localparam logic [DWIDTH-1:0] CMD_NOOP    = '0;

   state_t              state_q;
   logic                shadow_valid_q;
   logic [AWIDTH-1:0]   shadow_q;
   logic [AWIDTH-1:0]   addr_q;
   logic [DWIDTH-1:0]   data_q;
   logic                wr_ready_q;
   logic                byte_valid_q;
   logic [DWIDTH-1:0]   byte_q;
   logic                dmode_q;

   logic accept;
   logic hs;
   logic match;

   assign accept = WrValidIn & wr_ready_q;
   assign hs     = byte_valid_q & ByteReadyIn;
   // An invalidate on the accept edge must already force the full SetAddr sequence.
   assign match  = shadow_valid_q & ~InvalidateIn & (WrAddrIn == shadow_q);

`ifdef VCMD_TX_KEEPALIVE_EN
   localparam int CNT_W = $clog2(KEEPALIVE_CYCLES + 1);
   logic [CNT_W-1:0] idle_cnt_q;
   logic             ka_fire;
   assign ka_fire = (state_q == S_IDLE) && !WrValidIn &&
                    (idle_cnt_q == CNT_W'(KEEPALIVE_CYCLES - 1));
`endif

   always_ff @(posedge ClkIn) begin
      if (!RstNIn) begin
         state_q        <= S_IDLE;
         shadow_valid_q <= 1'b0;
         shadow_q       <= '0;
         addr_q         <= '0;
         data_q         <= '0;
         wr_ready_q     <= 1'b0;
         byte_valid_q   <= 1'b0;
         byte_q         <= '0;
         dmode_q        <= 1'b0;
`ifdef VCMD_TX_KEEPALIVE_EN
         idle_cnt_q     <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  addr_q       <= WrAddrIn;
                  data_q       <= WrDataIn;
                  wr_ready_q   <= 1'b0;
                  byte_valid_q <= 1'b1;
                  if (match) begin
                     state_q <= S_DATA;
                     byte_q  <= WrDataIn;
                     dmode_q <= 1'b1;
                  end else begin
                     state_q <= S_CMD;
                     byte_q  <= CMD_SETADDR;
                     dmode_q <= 1'b0;
                  end
`ifdef VCMD_TX_KEEPALIVE_EN
               end else if (ka_fire) begin
                  state_q      <= S_NOOP;
                  wr_ready_q   <= 1'b0;
                  byte_valid_q <= 1'b1;
                  byte_q       <= CMD_NOOP;
                  dmode_q      <= 1'b0;
               end else begin
`else
               end else begin
`endif
                  wr_ready_q <= 1'b1;
               end
            end
            S_CMD: if (hs) begin
               state_q <= S_PAGE;
               byte_q  <= DWIDTH'(addr_q[AWIDTH-1:16]);
            end
            S_PAGE: if (hs) begin
               state_q <= S_HIGH;
               byte_q  <= addr_q[15:8];
            end
            S_HIGH: if (hs) begin
               state_q <= S_LOW;
               byte_q  <= addr_q[7:0];
            end
            S_LOW: if (hs) begin
               state_q <= S_DATA;
               byte_q  <= data_q;
               dmode_q <= 1'b1;
            end
            S_DATA: if (hs) begin
               state_q        <= S_IDLE;
               byte_valid_q   <= 1'b0;
               wr_ready_q     <= 1'b1;
               shadow_q       <= addr_q + AWIDTH'(1);
               shadow_valid_q <= 1'b1;
            end
            S_NOOP: if (hs) begin
               state_q      <= S_IDLE;
               byte_valid_q <= 1'b0;
               wr_ready_q   <= 1'b1;
            end
            default: begin
               state_q      <= S_IDLE;
               byte_valid_q <= 1'b0;
               wr_ready_q   <= 1'b1;
            end
         endcase
         // Invalidate overrides a same-edge shadow set from the DATA handshake.
         if (InvalidateIn) shadow_valid_q <= 1'b0;
`ifdef VCMD_TX_KEEPALIVE_EN
         if (accept || hs || ka_fire) idle_cnt_q <= '0;
         else if (state_q == S_IDLE && !WrValidIn) idle_cnt_q <= idle_cnt_q + CNT_W'(1);
`endif
      end
   end

   assign WrReadyOut   = wr_ready_q;
   assign ByteValidOut = byte_valid_q;
   assign ByteOut      = byte_q;
   assign DataModeOut  = dmode_q;

endmodule

// File: tb/tb_vcmd_tx.sv
// Bench for vcmd_tx: randomized writes checked against a queue-based stream model.
module tb_vcmd_tx;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          RstNIn = 1'b0;
   logic          WrValidIn = 1'b0;
   logic          WrReadyOut;
   logic [AW-1:0] WrAddrIn = '0;
   logic [7:0]    WrDataIn = '0;
   logic          InvalidateIn = 1'b0;
   logic          ByteValidOut;
   logic          ByteReadyIn;
   logic [7:0]    ByteOut;
   logic          DataModeOut;

   always #5 clk = ~clk;

   vcmd_tx #(.AWIDTH(AW), .DWIDTH(8), .KEEPALIVE_CYCLES(8)) dut (
      .ClkIn(clk), .RstNIn(RstNIn), .WrValidIn(WrValidIn), .WrReadyOut(WrReadyOut),
      .WrAddrIn(WrAddrIn), .WrDataIn(WrDataIn), .InvalidateIn(InvalidateIn),
      .ByteValidOut(ByteValidOut), .ByteReadyIn(ByteReadyIn), .ByteOut(ByteOut),
      .DataModeOut(DataModeOut)
   );

   int checks = 0;
   int errors = 0;

   logic [8:0]    exp_q[$];
   logic [8:0]    obs_q[$];
   logic [AW-1:0] sh = '0;
   bit            sh_valid = 0;

   bit   rnd_ready = 0;
   logic man_ready = 1'b1;
   logic rnd_bit = 1'b1;
   assign ByteReadyIn = rnd_ready ? rnd_bit : man_ready;

   always @(posedge clk) begin
      #1;
      rnd_bit = ($urandom % 4) != 0;
   end

   // Receiver-side view of the stream: {C/D flag, byte} per handshake.
   always @(negedge clk) begin
      if (RstNIn && ByteValidOut && ByteReadyIn) obs_q.push_back({DataModeOut, ByteOut});
   end

   // Reference: receiver keeps an auto-incremented address; a write only needs
   // SetAddr when that address is unknown or differs.
   task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d, input bit inv);
      int n = 0;
      @(negedge clk);
      while (!WrReadyOut && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!WrReadyOut) begin
         errors++;
         $display("FAIL wr_ready_timeout got %0b want 1", WrReadyOut);
      end
      if (inv) sh_valid = 0;
      if (sh_valid && a == sh) begin
         exp_q.push_back({1'b1, d});
      end else begin
         exp_q.push_back({1'b0, 8'h01});
         exp_q.push_back({1'b0, 8'(a >> 16)});
         exp_q.push_back({1'b0, 8'(a >> 8)});
         exp_q.push_back({1'b0, 8'(a)});
         exp_q.push_back({1'b1, d});
      end
      sh       = AW'(a + 1);
      sh_valid = 1;
      WrValidIn    = 1'b1;
      WrAddrIn     = a;
      WrDataIn     = d;
      InvalidateIn = inv;
      @(posedge clk);
      #1;
      WrValidIn    = 1'b0;
      InvalidateIn = 1'b0;
   endtask

   task automatic drain(output bit ok);
      int n = 0;
      ok = 0;
      while (n < 2000) begin
         @(negedge clk);
         #1;
         if (obs_q.size() >= exp_q.size() && WrReadyOut) begin
            ok = 1;
            break;
         end
         n++;
      end
   endtask

   task automatic test_reset();
      RstNIn    = 1'b0;
      WrValidIn = 1'b1;
      WrAddrIn  = 18'h12345;
      WrDataIn  = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (ByteValidOut !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0b want 0", ByteValidOut);
         end
         checks++;
         if (WrReadyOut !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %0b want 0", WrReadyOut);
         end
      end
      RstNIn    = 1'b1;
      WrValidIn = 1'b0;
      sh_valid  = 0;
      sh        = '0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (WrReadyOut !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_ready got %0b want 1", WrReadyOut);
      end
      checks++;
      if ({ByteValidOut, DataModeOut, ByteOut} !== 10'h000) begin
         errors++;
         $display("FAIL post_reset_outputs got %h want 000", {ByteValidOut, DataModeOut, ByteOut});
      end
   endtask

   task automatic test_first_write();
      bit ok;
      exp_q.delete();
      obs_q.delete();
      man_ready = 1'b1;
      do_write(18'h12345, 8'hAB, 0);
      @(negedge clk);
      checks++;
      if ({ByteValidOut, DataModeOut, ByteOut} !== {2'b10, 8'h01}) begin
         errors++;
         $display("FAIL first_latency got %h want 201", {ByteValidOut, DataModeOut, ByteOut});
      end
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL first_drain got timeout want idle");
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL first_len got %0d want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         logic [8:0] o;
         o = (i < obs_q.size()) ? obs_q[i] : 9'h1FF;
         checks++;
         if (o !== exp_q[i]) begin
            errors++;
            $display("FAIL first_byte%0d got %h want %h", i, o, exp_q[i]);
         end
      end
   endtask

   task automatic test_sequential();
      bit ok;
      exp_q.delete();
      obs_q.delete();
      do_write(18'h12346, 8'hCD, 0);
      @(negedge clk);
      checks++;
      if ({ByteValidOut, DataModeOut, ByteOut} !== {2'b11, 8'hCD}) begin
         errors++;
         $display("FAIL match_latency got %h want 3cd", {ByteValidOut, DataModeOut, ByteOut});
      end
      do_write(18'h00010, 8'h11, 0);
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL seq_drain got timeout want idle");
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL seq_len got %0d want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         logic [8:0] o;
         o = (i < obs_q.size()) ? obs_q[i] : 9'h1FF;
         checks++;
         if (o !== exp_q[i]) begin
            errors++;
            $display("FAIL seq_byte%0d got %h want %h", i, o, exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      exp_q.delete();
      obs_q.delete();
      man_ready = 1'b0;
      do_write(18'h12345, 8'h5A, 0);
      man_ready = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      man_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({ByteValidOut, DataModeOut, ByteOut} !== {2'b10, 8'h23}) begin
            errors++;
            $display("FAIL bp_hold%0d got %h want 223", i, {ByteValidOut, DataModeOut, ByteOut});
         end
      end
      man_ready = 1'b1;
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_drain got timeout want idle");
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL bp_len got %0d want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         logic [8:0] o;
         o = (i < obs_q.size()) ? obs_q[i] : 9'h1FF;
         checks++;
         if (o !== exp_q[i]) begin
            errors++;
            $display("FAIL bp_byte%0d got %h want %h", i, o, exp_q[i]);
         end
      end
   endtask

   task automatic test_wrap_invalidate();
      bit ok;
      exp_q.delete();
      obs_q.delete();
      man_ready = 1'b1;
      do_write(18'h3FFFF, 8'hE1, 0);
      do_write(18'h00000, 8'hE2, 0);
      @(negedge clk);
      while (!WrReadyOut) @(negedge clk);
      #1;
      InvalidateIn = 1'b1;
      @(posedge clk);
      #1;
      InvalidateIn = 1'b0;
      sh_valid = 0;
      do_write(18'h00001, 8'hE3, 0);
      do_write(18'h00002, 8'hE4, 1);
      do_write(18'h00003, 8'hE5, 0);
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wrap_drain got timeout want idle");
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL wrap_len got %0d want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         logic [8:0] o;
         o = (i < obs_q.size()) ? obs_q[i] : 9'h1FF;
         checks++;
         if (o !== exp_q[i]) begin
            errors++;
            $display("FAIL wrap_byte%0d got %h want %h", i, o, exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      logic [AW-1:0] a;
      exp_q.delete();
      obs_q.delete();
      rnd_ready = 1;
      for (int k = 0; k < 40; k++) begin
         case ($urandom % 4)
            0, 1:    a = sh;
            2:       a = 18'h3FFFF;
            default: a = AW'($urandom);
         endcase
         do_write(a, 8'($urandom), ($urandom % 6) == 0);
      end
      drain(ok);
      rnd_ready = 0;
      man_ready = 1'b1;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rand_drain got timeout want idle");
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rand_len got %0d want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         logic [8:0] o;
         o = (i < obs_q.size()) ? obs_q[i] : 9'h1FF;
         checks++;
         if (o !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_byte%0d got %h want %h", i, o, exp_q[i]);
         end
      end
   endtask

   task automatic test_keepalive();
      bit ok;
      int first;
      exp_q.delete();
      obs_q.delete();
      man_ready = 1'b1;
      do_write(18'h00100, 8'h77, 0);
      drain(ok);
      obs_q.delete();
      exp_q.delete();
      first = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (ByteValidOut && first == 0) first = n;
      end
`ifdef VCMD_TX_KEEPALIVE_EN
      checks++;
      if (first < 7 || first > 12) begin
         errors++;
         $display("FAIL ka_arrival got cycle %0d want 7..12", first);
      end
      checks++;
      if (obs_q.size() == 0 || obs_q[0] !== 9'h000) begin
         errors++;
         $display("FAIL ka_noop got %h want 000", (obs_q.size() != 0) ? obs_q[0] : 9'h1FF);
      end
      obs_q.delete();
      do_write(sh, 8'h88, 0);
      drain(ok);
      checks++;
      if (!ok || obs_q.size() == 0 || obs_q[0] !== 9'h188) begin
         errors++;
         $display("FAIL ka_shadow got %h want 188", (obs_q.size() != 0) ? obs_q[0] : 9'h1FF);
      end
`else
      checks++;
      if (first != 0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL idle_quiet got %0d bytes want 0", obs_q.size());
      end
`endif
   endtask

   initial begin
      test_reset();
      test_first_write();
      test_sequential();
      test_backpressure();
      test_wrap_invalidate();
      test_random();
      test_keepalive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule
